// File: rtl/tych_mpi_master.sv
// AXI4-Lite slave to MPI initiator bridge: each single-beat AXI read or write becomes
// one MPI request, completed by ack or timeout and returned as an AXI response.
module tych_mpi_master #(
    parameter int MPI_AWIDTH = 32,
    parameter int MPI_DWIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    // AXI4-Lite write address
    input  logic [MPI_AWIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    // AXI4-Lite write data
    input  logic [MPI_DWIDTH-1:0] s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    // AXI4-Lite write response
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    // AXI4-Lite read address
    input  logic [MPI_AWIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // AXI4-Lite read data
    output logic [MPI_DWIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // MPI initiator
    output logic [MPI_AWIDTH-1:0] mpi_if_address,
    output logic [MPI_DWIDTH-1:0] mpi_if_wr_data,
    output logic [3:0]            mpi_if_wr_strb,
    output logic                  mpi_if_wr_req,
    output logic                  mpi_if_rd_req,
    output logic                  mpi_if_enable,
    input  logic [MPI_DWIDTH-1:0] mpi_if_rd_data,
    input  logic                  mpi_if_ack,
    input  logic                  mpi_if_error
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_INC = CW'(1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        WR_RESP,
        RD_RESP
    } state_t;

    state_t state_q, state_d;

    // Holding registers
    logic                  aw_full_q;
    logic [MPI_AWIDTH-1:0] aw_addr_q;
    logic                  w_full_q;
    logic [MPI_DWIDTH-1:0] w_data_q;
    logic [3:0]            w_strb_q;
    logic                  ar_full_q;
    logic [MPI_AWIDTH-1:0] ar_addr_q;

    // Arbitration, request and response registers
    logic                  rr_rd_q;
    logic [CW-1:0]         cnt_q;
    logic [MPI_AWIDTH-1:0] addr_q;
    logic [MPI_DWIDTH-1:0] wdata_q;
    logic [3:0]            strb_q;
    logic [MPI_DWIDTH-1:0] rdata_q;
    logic [1:0]            bresp_q;
    logic [1:0]            rresp_q;

    // Decoded control
    logic       aw_hs, w_hs, ar_hs;
    logic       wr_elig, rd_elig;
    logic       launch_rd, launch_wr;
    logic       in_req, acked, timed_out, done;
    logic [1:0] resp_d;

    always_comb begin
        aw_hs     = s_axi_awvalid && s_axi_awready;
        w_hs      = s_axi_wvalid && s_axi_wready;
        ar_hs     = s_axi_arvalid && s_axi_arready;
        wr_elig   = aw_full_q && w_full_q;
        rd_elig   = ar_full_q;
        // Read wins a tie only when the round-robin pointer favours it
        launch_rd = (state_q == IDLE) && rd_elig && (rr_rd_q || !wr_elig);
        launch_wr = (state_q == IDLE) && wr_elig && !(rd_elig && rr_rd_q);
        in_req    = (state_q == WR_REQ) || (state_q == RD_REQ);
        acked     = in_req && mpi_if_ack;
        timed_out = (TIMEOUT != 0) && in_req && !mpi_if_ack && (cnt_q == TO_LAST);
        done      = acked || timed_out;
        if (timed_out)
            resp_d = RESP_DECERR;
        else if (mpi_if_error)
            resp_d = RESP_SLVERR;
        else
            resp_d = RESP_OKAY;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (launch_rd)
                    state_d = RD_REQ;
                else if (launch_wr)
                    state_d = WR_REQ;
            end
            WR_REQ:  if (done) state_d = WR_RESP;
            RD_REQ:  if (done) state_d = RD_RESP;
            WR_RESP: if (s_axi_bready) state_d = IDLE;
            RD_RESP: if (s_axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        s_axi_awready  = !aw_full_q && !rst;
        s_axi_wready   = !w_full_q && !rst;
        s_axi_arready  = !ar_full_q && !rst;
        s_axi_bvalid   = (state_q == WR_RESP);
        s_axi_rvalid   = (state_q == RD_RESP);
        s_axi_bresp    = bresp_q;
        s_axi_rresp    = rresp_q;
        s_axi_rdata    = rdata_q;
        mpi_if_enable  = in_req;
        mpi_if_wr_req  = (state_q == WR_REQ);
        mpi_if_rd_req  = (state_q == RD_REQ);
        mpi_if_address = addr_q;
        mpi_if_wr_data = wdata_q;
        mpi_if_wr_strb = strb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_full_q <= 1'b0;
            ar_addr_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= s_axi_awaddr;
            end else if (done && state_q == WR_REQ) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end else if (done && state_q == WR_REQ) begin
                w_full_q <= 1'b0;
            end
            if (ar_hs) begin
                ar_full_q <= 1'b1;
                ar_addr_q <= s_axi_araddr;
            end else if (done && state_q == RD_REQ) begin
                ar_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_rd_q <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            bresp_q <= '0;
            rresp_q <= '0;
        end else begin
            if (launch_rd) begin
                rr_rd_q <= !rr_rd_q;
                cnt_q   <= '0;
                addr_q  <= ar_addr_q;
                wdata_q <= '0;
                strb_q  <= '0;
            end else if (launch_wr) begin
                rr_rd_q <= !rr_rd_q;
                cnt_q   <= '0;
                addr_q  <= aw_addr_q;
                wdata_q <= w_data_q;
                strb_q  <= w_strb_q;
            end else if (in_req && !done) begin
                cnt_q <= cnt_q + CNT_INC;
            end
            if (done && state_q == WR_REQ)
                bresp_q <= resp_d;
            if (done && state_q == RD_REQ) begin
                rresp_q <= resp_d;
                rdata_q <= acked ? mpi_if_rd_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_tych_mpi_master.sv
// Directed bench for tych_mpi_master with TIMEOUT = 8; the bench plays both AXI master
// and MPI responder, one step per clock.
module tb_tych_mpi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] mpi_if_address;
    logic [31:0] mpi_if_wr_data;
    logic [3:0]  mpi_if_wr_strb;
    logic        mpi_if_wr_req;
    logic        mpi_if_rd_req;
    logic        mpi_if_enable;
    logic [31:0] mpi_if_rd_data;
    logic        mpi_if_ack;
    logic        mpi_if_error;

    int checks = 0;
    int passed = 0;

    tych_mpi_master #(
        .MPI_AWIDTH(32),
        .MPI_DWIDTH(32),
        .TIMEOUT   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .mpi_if_address(mpi_if_address),
        .mpi_if_wr_data(mpi_if_wr_data),
        .mpi_if_wr_strb(mpi_if_wr_strb),
        .mpi_if_wr_req (mpi_if_wr_req),
        .mpi_if_rd_req (mpi_if_rd_req),
        .mpi_if_enable (mpi_if_enable),
        .mpi_if_rd_data(mpi_if_rd_data),
        .mpi_if_ack    (mpi_if_ack),
        .mpi_if_error  (mpi_if_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = d;
        s_axi_wstrb   = s;
        s_axi_wvalid  = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic send_rd(input logic [31:0] a);
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        step();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] d, input logic err);
        mpi_if_ack     = 1'b1;
        mpi_if_rd_data = d;
        mpi_if_error   = err;
        step();
        mpi_if_ack     = 1'b0;
        mpi_if_rd_data = '0;
        mpi_if_error   = 1'b0;
    endtask

    task automatic b_take();
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
    endtask

    task automatic r_take();
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0;  s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        mpi_if_rd_data = '0; mpi_if_ack = 1'b0; mpi_if_error = 1'b0;
        step();
        step();
        chk("rst_enable", 32'(mpi_if_enable), 32'd0);
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_address", mpi_if_address, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_awready", 32'(s_axi_awready), 32'd1);
        chk("idle_arready", 32'(s_axi_arready), 32'd1);

        // Single write, ack in second enable cycle (pointer read -> write)
        send_wr(32'h10, 32'hDEADBEEF, 4'hF);
        chk("w1_awready_full", 32'(s_axi_awready), 32'd0);
        chk("w1_wready_full", 32'(s_axi_wready), 32'd0);
        chk("w1_no_launch_yet", 32'(mpi_if_enable), 32'd0);
        step();
        chk("w1_enable_c1", 32'(mpi_if_enable), 32'd1);
        chk("w1_wr_req", 32'(mpi_if_wr_req), 32'd1);
        chk("w1_rd_req", 32'(mpi_if_rd_req), 32'd0);
        chk("w1_address", mpi_if_address, 32'h10);
        chk("w1_wr_data", mpi_if_wr_data, 32'hDEADBEEF);
        chk("w1_strb", 32'(mpi_if_wr_strb), 32'hF);
        step();
        chk("w1_enable_c2", 32'(mpi_if_enable), 32'd1);
        ack_now(32'h0, 1'b0);
        chk("w1_enable_off", 32'(mpi_if_enable), 32'd0);
        chk("w1_wr_req_off", 32'(mpi_if_wr_req), 32'd0);
        chk("w1_bvalid", 32'(s_axi_bvalid), 32'd1);
        chk("w1_bresp", 32'(s_axi_bresp), 32'd0);
        chk("w1_awready_free", 32'(s_axi_awready), 32'd1);
        b_take();
        chk("w1_bvalid_clr", 32'(s_axi_bvalid), 32'd0);

        // Read with responder error (pointer write -> read)
        send_rd(32'h24);
        step();
        chk("r2_rd_req", 32'(mpi_if_rd_req), 32'd1);
        chk("r2_address", mpi_if_address, 32'h24);
        chk("r2_strb_zero", 32'(mpi_if_wr_strb), 32'd0);
        ack_now(32'h1234, 1'b1);
        chk("r2_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("r2_rdata", s_axi_rdata, 32'h1234);
        chk("r2_rresp", 32'(s_axi_rresp), 32'h2);
        chk("r2_enable_off", 32'(mpi_if_enable), 32'd0);
        r_take();
        chk("r2_rvalid_clr", 32'(s_axi_rvalid), 32'd0);

        // Read timeout: enable high exactly 8 cycles (pointer read -> write)
        send_rd(32'h30);
        step();
        chk("t3_enable_c1", 32'(mpi_if_enable), 32'd1);
        repeat (7) step();
        chk("t3_enable_c8", 32'(mpi_if_enable), 32'd1);
        chk("t3_no_rvalid_c8", 32'(s_axi_rvalid), 32'd0);
        step();
        chk("t3_enable_off", 32'(mpi_if_enable), 32'd0);
        chk("t3_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("t3_rresp", 32'(s_axi_rresp), 32'h3);
        chk("t3_rdata", s_axi_rdata, 32'h0);
        r_take();

        // Following write, ack in first cycle; then B backpressure with queued AW/W and AR
        send_wr(32'h44, 32'hCAFEF00D, 4'h3);
        step();
        chk("w4_wr_req", 32'(mpi_if_wr_req), 32'd1);
        chk("w4_strb", 32'(mpi_if_wr_strb), 32'h3);
        ack_now(32'h0, 1'b0);
        chk("w4_bvalid", 32'(s_axi_bvalid), 32'd1);
        send_wr(32'h50, 32'h11111111, 4'hF);
        chk("bp_bvalid_1", 32'(s_axi_bvalid), 32'd1);
        step();
        step();
        chk("bp_bresp_3", 32'(s_axi_bresp), 32'd0);
        send_rd(32'h60);
        chk("bp_arready_low", 32'(s_axi_arready), 32'd0);
        chk("bp_bvalid_5", 32'(s_axi_bvalid), 32'd1);
        chk("bp_bresp_5", 32'(s_axi_bresp), 32'd0);
        chk("bp_no_launch", 32'(mpi_if_enable), 32'd0);
        b_take();
        chk("bp_bubble", 32'(mpi_if_enable), 32'd0);
        step();
        chk("ord_first_is_rd", 32'(mpi_if_rd_req), 32'd1);
        chk("ord_first_addr", mpi_if_address, 32'h60);
        ack_now(32'hABCD0001, 1'b0);
        chk("ord_rdata", s_axi_rdata, 32'hABCD0001);
        r_take();
        chk("ord_bubble", 32'(mpi_if_enable), 32'd0);
        step();
        chk("ord_second_is_wr", 32'(mpi_if_wr_req), 32'd1);
        chk("ord_second_addr", mpi_if_address, 32'h50);
        chk("ord_second_data", mpi_if_wr_data, 32'h11111111);
        ack_now(32'h0, 1'b0);
        b_take();

        // Lone read flips pointer to write; pair queued meanwhile launches write first
        send_rd(32'h70);
        step();
        chk("p2_rd_req", 32'(mpi_if_rd_req), 32'd1);
        send_wr(32'h80, 32'h22222222, 4'hC);
        ack_now(32'h5555, 1'b0);
        chk("p2_rdata", s_axi_rdata, 32'h5555);
        send_rd(32'h84);
        chk("p2_rvalid_held", 32'(s_axi_rvalid), 32'd1);
        r_take();
        step();
        chk("p2_first_is_wr", 32'(mpi_if_wr_req), 32'd1);
        chk("p2_first_addr", mpi_if_address, 32'h80);
        chk("p2_first_strb", 32'(mpi_if_wr_strb), 32'hC);
        ack_now(32'h0, 1'b0);
        b_take();
        step();
        chk("p2_second_is_rd", 32'(mpi_if_rd_req), 32'd1);
        chk("p2_second_addr", mpi_if_address, 32'h84);
        ack_now(32'h77, 1'b0);
        r_take();

        // Reset while enable is high
        send_wr(32'h90, 32'h33333333, 4'hF);
        step();
        chk("rm_enable_on", 32'(mpi_if_enable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_enable_async", 32'(mpi_if_enable), 32'd0);
        chk("rm_wr_req", 32'(mpi_if_wr_req), 32'd0);
        chk("rm_address", mpi_if_address, 32'd0);
        chk("rm_wr_data", mpi_if_wr_data, 32'd0);
        chk("rm_strb", 32'(mpi_if_wr_strb), 32'd0);
        chk("rm_bvalid", 32'(s_axi_bvalid), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("rm_no_bresp", 32'(s_axi_bvalid), 32'd0);
        chk("rm_no_relaunch", 32'(mpi_if_enable), 32'd0);
        send_rd(32'hA0);
        step();
        chk("rm_next_rd_req", 32'(mpi_if_rd_req), 32'd1);
        chk("rm_next_addr", mpi_if_address, 32'hA0);
        ack_now(32'h99, 1'b0);
        chk("rm_next_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("rm_next_rdata", s_axi_rdata, 32'h99);
        chk("rm_next_rresp", 32'(s_axi_rresp), 32'd0);
        r_take();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
